// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : music_pkg
//  Description : Shared definitions for the music player sequencing logic.
//                Sequencer state encoding, play-mode codes, and the shuffle
//                LFSR seed, taps and feedback helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package music_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_PLAYING = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SEQ        = 2'd0;
  localparam logic [1:0] MODE_REPEAT_ALL = 2'd1;
  localparam logic [1:0] MODE_REPEAT_ONE = 2'd2;
  localparam logic [1:0] MODE_SHUFFLE    = 2'd3;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB: taps on bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'h5A;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic lfsr_feedback(input logic [7:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shuffle_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : shuffle_lfsr
//  Description : 8-bit Fibonacci LFSR used as the random source for shuffle
//                play. Holds the seed while reset is asserted.
//  Ports       : clk, reset (async, active-high), en_i (step enable),
//                lfsr_o (current LFSR state).
//  Revision    : 1.0 - initial release
// ============================================================================
module shuffle_lfsr
  import music_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/playlist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : playlist_sequencer
//  Description : Playback sequencer. Owns play / song / reset_play, advances
//                through the playlist on song_done according to the play
//                mode with a beat-timed silent gap, and handles next/prev
//                navigation with wrap-around.
//  Ports       : clk, reset (async, active-high); play_pause, next, prev,
//                song_done, beat (one-cycle pulses); mode (play mode);
//                play, song, reset_play, gap_active, playlist_done (registered).
//  Config      : define SHUFFLE_EN to include the LFSR and real shuffle play;
//                otherwise mode 3 behaves as repeat-all.
//  Revision    : 1.0 - initial release
// ============================================================================
module playlist_sequencer
  import music_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int GAP_BEATS = 8,
  parameter int GAP_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_pause,
  input  logic                 next,
  input  logic                 prev,
  input  logic [1:0]           mode,
  input  logic                 song_done,
  input  logic                 beat,
  output logic                 play,
  output logic [SONG_BITS-1:0] song,
  output logic                 reset_play,
  output logic                 gap_active,
  output logic                 playlist_done
);

  localparam logic [SONG_BITS-1:0] SONG_ONE  = SONG_BITS'(1);
  localparam logic [SONG_BITS-1:0] SONG_LAST = '1;
  localparam logic [GAP_BITS-1:0]  GAP_END   = GAP_BITS'(GAP_BEATS);
  localparam logic [GAP_BITS-1:0]  GAP_ONE   = GAP_BITS'(1);

  state_t                 state_q, state_d;
  logic                   resume_q, resume_d;
  logic [SONG_BITS-1:0]   song_q, song_d;
  logic                   done_q, done_d;
  logic [GAP_BITS-1:0]    cnt_q, cnt_d;
  logic                   play_q, reset_play_q, gap_active_q;

  // Mode-driven choice of the song that follows the current one.
  logic [SONG_BITS-1:0]   sel_song;
  logic                   sel_resume;
  logic                   sel_done;

`ifdef SHUFFLE_EN
  logic [7:0]             lfsr;
  logic [SONG_BITS-1:0]   cand;

  shuffle_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );

  assign cand = lfsr[SONG_BITS-1:0];
`endif

  always_comb begin
    sel_song   = song_q + SONG_ONE;
    sel_resume = 1'b1;
    sel_done   = 1'b0;
    case (mode)
      MODE_SEQ: begin
        if (song_q == SONG_LAST) begin
          sel_song   = '0;
          sel_resume = 1'b0;
          sel_done   = 1'b1;
        end
      end
      MODE_REPEAT_ONE: sel_song = song_q;
`ifdef SHUFFLE_EN
      // Never replay the song that just finished.
      MODE_SHUFFLE: sel_song = (cand == song_q) ? cand + SONG_ONE : cand;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    song_d   = song_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_INIT: state_d = resume_q ? ST_PLAYING : ST_PAUSED;
      ST_PAUSED: begin
        if (next) begin
          song_d = song_q + SONG_ONE; resume_d = 1'b0; state_d = ST_INIT;
        end else if (prev) begin
          song_d = song_q - SONG_ONE; resume_d = 1'b0; state_d = ST_INIT;
        end else if (play_pause) begin
          state_d = ST_PLAYING; done_d = 1'b0;
        end
      end
      ST_PLAYING: begin
        if (next) begin
          song_d = song_q + SONG_ONE; resume_d = 1'b1; state_d = ST_INIT;
        end else if (prev) begin
          song_d = song_q - SONG_ONE; resume_d = 1'b1; state_d = ST_INIT;
        end else if (song_done) begin
          cnt_d = '0; state_d = ST_GAP;
        end else if (play_pause) begin
          state_d = ST_PAUSED;
        end
      end
      ST_GAP: begin
        if (next) begin
          song_d = song_q + SONG_ONE; resume_d = 1'b1; state_d = ST_INIT;
        end else if (prev) begin
          song_d = song_q - SONG_ONE; resume_d = 1'b1; state_d = ST_INIT;
        end else if (play_pause) begin
          // Skip ahead but land paused on the selected song.
          song_d = sel_song; resume_d = 1'b0; done_d = done_q | sel_done;
          state_d = ST_INIT;
        end else if (cnt_q == GAP_END) begin
          song_d = sel_song; resume_d = sel_resume; done_d = done_q | sel_done;
          state_d = ST_INIT;
        end else if (beat) begin
          cnt_d = cnt_q + GAP_ONE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      resume_q     <= 1'b0;
      song_q       <= '0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      play_q       <= 1'b0;
      reset_play_q <= 1'b1;
      gap_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      song_q       <= song_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      // Status outputs are registered from the next state so they line up
      // with the state register.
      play_q       <= (state_d == ST_PLAYING);
      reset_play_q <= (state_d == ST_INIT);
      gap_active_q <= (state_d == ST_GAP);
    end
  end

  assign play          = play_q;
  assign song          = song_q;
  assign reset_play    = reset_play_q;
  assign gap_active    = gap_active_q;
  assign playlist_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_playlist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_playlist_sequencer
//  Description : Scoreboard bench for playlist_sequencer. Stimulus pushes the
//                expected sequence of output tuples {play, reset_play,
//                gap_active, playlist_done, song} plus the number of beat
//                pulses expected between changes; the monitor pops and checks
//                each time the output tuple changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_playlist_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_pause, next, prev, song_done, beat;
  logic [1:0] mode;
  logic       play, reset_play, gap_active, playlist_done;
  logic [1:0] song;

  playlist_sequencer #(.SONG_BITS(2), .GAP_BEATS(8), .GAP_BITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .play_pause    (play_pause),
    .next          (next),
    .prev          (prev),
    .mode          (mode),
    .song_done     (song_done),
    .beat          (beat),
    .play          (play),
    .song          (song),
    .reset_play    (reset_play),
    .gap_active    (gap_active),
    .playlist_done (playlist_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] tup;
    int         beats;
    bit         song_x;
    bit         rec;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] played[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         end_req = 1'b0;
  bit         end_ack = 1'b0;

`ifdef SHUFFLE_EN
  localparam bit SHUF_X = 1'b1;
`else
  localparam bit SHUF_X = 1'b0;
`endif

  // ---------------- monitor / scoreboard ----------------
  logic [5:0] prev_tup;
  bit         have_prev = 1'b0;
  int         beat_cnt = 0;
  int         evt = 0;

  always @(negedge clk) begin
    logic [5:0] cur;
    logic [5:0] mask;
    logic [3:0] seen;
    exp_t       e;
    cur = {play, reset_play, gap_active, playlist_done, song};
    if (!have_prev || cur !== prev_tup) begin
      evt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change evt%0d got=%b", evt, cur);
      end else begin
        e = exp_q.pop_front();
        mask = e.song_x ? 6'b111100 : 6'b111111;
        if (((cur ^ e.tup) & mask) !== 6'b0 || beat_cnt != e.beats) begin
          n_fail++;
          $display("FAIL outputs evt%0d got p/r/g/d/song=%b beats=%0d want=%b beats=%0d",
                   evt, cur, beat_cnt, e.tup, e.beats);
        end
        if (e.rec) played.push_back(cur[1:0]);
      end
      prev_tup  = cur;
      have_prev = 1'b1;
      beat_cnt  = 0;
    end
    if (beat === 1'b1) beat_cnt++;

    if (end_req && !end_ack) begin
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL pending_events got=%0d want=0", exp_q.size());
      end
      seen = '0;
      foreach (played[i]) seen[played[i]] = 1'b1;
      for (int i = 1; i < played.size(); i++) begin
        n_chk++;
        if (played[i] == played[i-1]) begin
          n_fail++;
          $display("FAIL back_to_back idx%0d got=%0d want!=%0d", i, played[i], played[i-1]);
        end
      end
      n_chk++;
      if (seen != 4'hF) begin
        n_fail++;
        $display("FAIL shuffle_coverage got=%b want=1111", seen);
      end
      end_ack = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic n, input logic p, input logic pp,
                       input logic sd, input logic b);
    next = n; prev = p; play_pause = pp; song_done = sd; beat = b;
    tick();
    next = 0; prev = 0; play_pause = 0; song_done = 0; beat = 0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      pulse(0, 0, 0, 0, 1);
      idle(2);
    end
  endtask

  task automatic ex(input logic p, input logic r, input logic g, input logic d,
                    input logic [1:0] s, input int b, input bit x, input bit rec);
    exp_t e;
    e.tup = {p, r, g, d, s};
    e.beats = b;
    e.song_x = x;
    e.rec = rec;
    exp_q.push_back(e);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [1:0] cur_song;
    reset = 1; play_pause = 0; next = 0; prev = 0; song_done = 0; beat = 0;
    mode = 2'd1;

    ex(0,1,0,0,2'd0,0,0,0);                 // reset values
    idle(3);
    reset = 0;
    ex(0,0,0,0,2'd0,0,0,0);                 // one reset_play cycle, then paused
    idle(3);
    ex(1,0,0,0,2'd0,0,0,0);                 // play_pause -> playing
    pulse(0,0,1,0,0); idle(3);

    for (int s = 1; s <= 4; s++) begin      // next: 1,2,3, wrap to 0
      ex(0,1,0,0,2'(s),0,0,0);
      ex(1,0,0,0,2'(s),0,0,0);
      pulse(1,0,0,0,0); idle(3);
    end

    ex(0,1,0,0,2'd3,0,0,0);                 // prev at 0 -> 3
    ex(1,0,0,0,2'd3,0,0,0);
    pulse(0,1,0,0,0); idle(3);

    // repeat-all gap from song 3, stray song_done in the gap is ignored
    ex(0,0,1,0,2'd3,0,0,0);
    ex(0,1,0,0,2'd0,8,0,0);
    ex(1,0,0,0,2'd0,0,0,0);
    pulse(0,0,0,1,0); idle(1); gap(4); pulse(0,0,0,1,0); idle(1); gap(4); idle(5);

    // SEQ end of list
    ex(0,1,0,0,2'd3,0,0,0);
    ex(1,0,0,0,2'd3,0,0,0);
    pulse(0,1,0,0,0); idle(3);
    mode = 2'd0;
    ex(0,0,1,0,2'd3,0,0,0);
    ex(0,1,0,1,2'd0,8,0,0);
    ex(0,0,0,1,2'd0,0,0,0);
    pulse(0,0,0,1,0); idle(1); gap(8); idle(5);
    ex(1,0,0,0,2'd0,0,0,0);                 // play_pause clears playlist_done
    pulse(0,0,1,0,0); idle(3);

    // next + song_done + play_pause together: next wins
    mode = 2'd1;
    ex(0,1,0,0,2'd1,0,0,0);
    ex(1,0,0,0,2'd1,0,0,0);
    pulse(1,0,1,1,0); idle(3);

    // next + prev together: next wins
    ex(0,1,0,0,2'd2,0,0,0);
    ex(1,0,0,0,2'd2,0,0,0);
    pulse(1,1,0,0,0); idle(3);

    // play_pause during gap: skip ahead, land paused
    ex(0,0,1,0,2'd2,0,0,0);
    ex(0,1,0,0,2'd3,2,0,0);
    ex(0,0,0,0,2'd3,0,0,0);
    pulse(0,0,0,1,0); idle(1); gap(2); pulse(0,0,1,0,0); idle(3);

    // prev while paused stays paused
    ex(0,1,0,0,2'd2,0,0,0);
    ex(0,0,0,0,2'd2,0,0,0);
    pulse(0,1,0,0,0); idle(3);
    ex(1,0,0,0,2'd2,0,0,0);
    pulse(0,0,1,0,0); idle(3);

    // repeat-one
    mode = 2'd2;
    ex(0,0,1,0,2'd2,0,0,0);
    ex(0,1,0,0,2'd2,8,0,0);
    ex(1,0,0,0,2'd2,0,0,0);
    pulse(0,0,0,1,0); idle(1); gap(8); idle(5);

    // next during gap abandons it and resumes
    mode = 2'd1;
    ex(0,0,1,0,2'd2,0,0,0);
    ex(0,1,0,0,2'd3,2,0,0);
    ex(1,0,0,0,2'd3,0,0,0);
    pulse(0,0,0,1,0); idle(1); gap(2); pulse(1,0,0,0,0); idle(3);

    // mode 3 over 20 songs starting from song 3
    mode = 2'd3;
    cur_song = 2'd3;
    for (int i = 0; i < 20; i++) begin
      ex(0,0,1,0,cur_song,0,(i != 0) && SHUF_X,i == 0);
      cur_song = cur_song + 2'd1;
      ex(0,1,0,0,cur_song,8,SHUF_X,0);
      ex(1,0,0,0,cur_song,0,SHUF_X,1);
      pulse(0,0,0,1,0); idle(1); gap(8); idle(5);
    end

    idle(5);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) tick();
    if (!end_ack) begin
      $display("FAIL end_handshake got=0 want=1");
      $fatal(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
